// File: rtl/sd_pkg.sv
// Shared AHB encodings and FSM state type for the SD Wishbone-to-AHB DMA bridge.
package sd_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

endpackage

// File: rtl/sd_sel_decode.sv
// Maps a Wishbone byte-select onto an AHB transfer size and address low bits.
// Only naturally aligned byte, halfword and word selects are legal.
module sd_sel_decode
  import sd_pkg::*;
(
  input  logic [3:0] sel_i,
  output logic       legal_o,
  output logic [2:0] hsize_o,
  output logic [1:0] addr_lo_o
);

  always_comb begin
    legal_o   = 1'b1;
    hsize_o   = HSIZE_BYTE;
    addr_lo_o = 2'b00;
    case (sel_i)
      4'hf: hsize_o = HSIZE_WORD;
      4'h3: hsize_o = HSIZE_HALF;
      4'hc: begin
        hsize_o   = HSIZE_HALF;
        addr_lo_o = 2'b10;
      end
      4'h1: addr_lo_o = 2'b00;
      4'h2: addr_lo_o = 2'b01;
      4'h4: addr_lo_o = 2'b10;
      4'h8: addr_lo_o = 2'b11;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sd_wb2ahb_dma.sv
// Replays one Wishbone classic single transfer from the SD DMA as one AHB5 SINGLE transfer.
// All outputs registered; ack/err pulse 3 cycles after stb on a zero-wait slave.
module sd_wb2ahb_dma
  import sd_pkg::*;
#(
  parameter int unsigned        W_ADDR     = 32,
  parameter int unsigned        W_DATA     = 32,
  parameter logic [W_ADDR-1:0]  BASE_ADDR  = '0,
  parameter int unsigned        ADDR_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic              hexcl,
  input  logic              hready,
  input  logic              hresp,
  output logic [W_DATA-1:0] hwdata,
  input  logic [W_DATA-1:0] hrdata,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [1:0]          htrans_q, htrans_d;
  logic [W_ADDR-1:0]   haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [W_DATA-1:0]   hwdata_q, hwdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                dec_legal;
  logic [2:0]          dec_hsize;
  logic [1:0]          dec_addr_lo;
  logic [W_ADDR-1:0]   adr_full;
  logic                req;

  sd_sel_decode u_sel_decode (
    .sel_i     (wb_sel_i),
    .legal_o   (dec_legal),
    .hsize_o   (dec_hsize),
    .addr_lo_o (dec_addr_lo)
  );

  assign req      = wb_cyc_i & wb_stb_i;
  assign adr_full = BASE_ADDR + (W_ADDR'(wb_adr_i) << ADDR_SHIFT);

  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (dec_legal) begin
            // Low address bits come from the byte lanes, not from the Wishbone address.
            haddr_d  = (adr_full & ~W_ADDR'(3)) | W_ADDR'(dec_addr_lo);
            hwrite_d = wb_we_i;
            hsize_d  = dec_hsize;
            hwdata_d = W_DATA'(wb_dat_i);
            htrans_d = HTRANS_NONSEQ;
            state_d  = ST_ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (hready) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        // First cycle of a two-cycle error response has hready low and simply waits.
        if (hready) begin
          state_d = ST_RESP;
          if (hresp) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (!hwrite_q) rdata_d = 32'(hrdata);
          end
        end
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_WORD;
      hwdata_q <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hwdata    = hwdata_q;
  assign wb_dat_o  = rdata_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign busy      = busy_q;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_DATA_PRIV;
  assign hmastlock = 1'b0;
  assign hexcl     = 1'b0;

endmodule

// File: tb/tb_sd_wb2ahb_dma.sv
// Directed and random transfers against a behavioural AHB slave and a sel/latency model.
module tb_sd_wb2ahb_dma;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hready, hresp, hmastlock, hexcl, busy;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int beats = 0;
  int beat_cyc[$];
  logic [31:0] model_rdata = 32'h0;

  sd_wb2ahb_dma #(.W_ADDR(32), .W_DATA(32), .BASE_ADDR(BASE), .ADDR_SHIFT(0)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hexcl(hexcl),
    .hready(hready), .hresp(hresp), .hwdata(hwdata), .hrdata(hrdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Completed AHB address phases: NONSEQ seen while the slave is ready.
  always @(posedge clk) begin
    cyc_cnt++;
    if (!rst && htrans == 2'b10 && hready) begin
      beats++;
      beat_cyc.push_back(cyc_cnt);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Legal selects are 1, 2 or 4 contiguous lanes starting on a multiple of their count.
  function automatic void sel_model(input logic [3:0] s, output bit lg,
                                    output logic [2:0] sz, output logic [1:0] lo);
    int n;
    int l;
    logic [3:0] mask;
    n = $countones(s);
    l = 0;
    for (int i = 3; i >= 0; i--) if (s[i]) l = i;
    mask = 4'(((1 << n) - 1) << l);
    lg = (n == 1 || n == 2 || n == 4) && (s == mask) && ((l % (n == 0 ? 1 : n)) == 0);
    sz = (n == 0) ? 3'd0 : 3'($clog2(n));
    lo = 2'(l);
  endfunction

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int aw, input int dw, input bit serr,
                      input logic [31:0] rdv, input bit hold);
    bit lg;
    logic [2:0] sz;
    logic [1:0] lo;
    logic [31:0] exp_haddr;
    int exp_lat, ack_c, err_c, ns_c, awl, dwl, b0;
    bit dph, exp_ok, hw_ok;
    logic [31:0] ns_haddr;
    logic [2:0] ns_hsize;
    logic ns_hwrite;

    sel_model(sel, lg, sz, lo);
    exp_haddr = ((BASE + adr) & 32'hffff_fffc) | {30'd0, lo};
    exp_ok = lg && !serr;
    exp_lat = lg ? 3 + aw + dw : 1;
    if (lg && !serr && !we) model_rdata = rdv;
    b0 = beats;
    ack_c = -1; err_c = -1; ns_c = -1;
    awl = aw; dwl = dw; dph = 1'b0; hw_ok = 1'b1;
    ns_haddr = '0; ns_hsize = '0; ns_hwrite = 1'b0;

    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;

    for (int c = 1; c <= 40; c++) begin
      tick();
      if (wb_ack_o && ack_c < 0) ack_c = c;
      if (wb_err_o && err_c < 0) err_c = c;
      if (wb_ack_o || wb_err_o) begin
        hready = 1'b1; hresp = 1'b0;
        break;
      end
      hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
      if (dph) begin
        if (we && hwdata !== dat) hw_ok = 1'b0;
        if (dwl > 0) begin
          hready = 1'b0;
          hresp = serr && (dwl == 1);
          dwl--;
        end else begin
          hresp = serr;
          hrdata = rdv;
          dph = 1'b0;
        end
      end else if (htrans == 2'b10) begin
        if (ns_c < 0) begin
          ns_c = c; ns_haddr = haddr; ns_hsize = hsize; ns_hwrite = hwrite;
        end
        if (awl > 0) begin
          hready = 1'b0;
          awl--;
        end else begin
          dph = 1'b1;
        end
      end
    end
    if (!hold) begin
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    end

    chk("ack_cycle", 64'(ack_c), 64'(exp_ok ? exp_lat : -1));
    chk("err_cycle", 64'(err_c), 64'(exp_ok ? -1 : exp_lat));
    chk("nonseq_cycle", 64'(ns_c), 64'(lg ? 1 : -1));
    chk("beat_count", 64'(beats - b0), 64'(lg ? 1 : 0));
    if (lg) begin
      chk("haddr", 64'(ns_haddr), 64'(exp_haddr));
      chk("hsize", 64'(ns_hsize), 64'(sz));
      chk("hwrite", 64'(ns_hwrite), 64'(we));
      if (we) chk("hwdata_held", 64'(hw_ok), 64'd1);
    end
    tick();
    chk("gap_pulse", 64'({wb_ack_o, wb_err_o}), 64'd0);
    chk("gap_busy", 64'(busy), 64'd1);
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("wb_dat_o", 64'(wb_dat_o), 64'(model_rdata));
  endtask

  initial begin
    int n0;
    bit we;
    int dw;
    bit se;
    rst = 1'b1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = 0; wb_sel_i = 0; wb_dat_i = 0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    #12;
    chk("rst_htrans", 64'(htrans), 64'd0);
    chk("rst_haddr", 64'(haddr), 64'd0);
    chk("rst_hwrite", 64'(hwrite), 64'd0);
    chk("rst_hsize", 64'(hsize), 64'd2);
    chk("rst_hwdata", 64'(hwdata), 64'd0);
    chk("rst_wb_outs", 64'({wb_dat_o, wb_ack_o, wb_err_o, busy}), 64'd0);
    chk("const_ahb", 64'({hburst, hprot, hmastlock, hexcl}), 64'({3'b000, 4'b0011, 1'b0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    tick();

    xfer(1'b0, 32'h100, 4'hf, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    xfer(1'b1, 32'h204, 4'h4, 32'h00AB0000, 0, 2, 1'b0, 32'h0, 1'b0);
    xfer(1'b0, 32'h300, 4'h5, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0);
    xfer(1'b0, 32'h400, 4'hf, 32'h0, 0, 1, 1'b1, 32'h12345678, 1'b0);

    n0 = beat_cyc.size();
    for (int k = 0; k < 4; k++)
      xfer(1'b0, 32'h500 + 32'(4 * k), 4'hf, 32'h0, 0, 0, 1'b0, $urandom, k != 3);
    chk("b2b_beats", 64'(beat_cyc.size() - n0), 64'd4);
    if (beat_cyc.size() - n0 == 4)
      for (int k = 1; k < 4; k++)
        chk("b2b_spacing", 64'(beat_cyc[n0 + k] - beat_cyc[n0 + k - 1]), 64'd5);

    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h600; wb_sel_i = 4'hf;
    tick();
    chk("pre_rst_nonseq", 64'(htrans), 64'd2);
    hready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_htrans", 64'(htrans), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; hready = 1'b1;
    model_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    xfer(1'b0, 32'h700, 4'h3, 32'h0, 1, 0, 1'b0, 32'hCAFEF00D, 1'b0);

    for (int k = 0; k < 20; k++) begin
      we = 1'($urandom_range(0, 1));
      dw = $urandom_range(0, 2);
      se = ($urandom_range(0, 3) == 0);
      if (se && dw == 0) dw = 1;
      xfer(we, $urandom, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 2), dw, se, $urandom, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
